not_gate_exerciser: RTL and testbench

NOT_GATE_EXERCISER -- requirements
Module: not_gate_exerciser

---
 rtl/not_gate_exerciser.sv | 152 +++++++++++++++
 tb/tb_not_gate_exerciser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/not_gate_exerciser.sv
// Built-in exerciser for a single inverter: drives alternating vectors,
// waits SETTLE cycles, checks dut_y == ~dut_a and counts mismatches.
// Ports: clk, rst_n (async, active-low), start -> run request;
//   dut_a -> stimulus, dut_y <- response (synchronous to clk);
//   busy, done (1-cycle pulse), pass, err_count[7:0] -> status.
// Optional FIRST_FAIL_LOG_EN adds fail_idx[7:0] and fail_valid,
// which record the index of the first failing vector in a run.
module not_gate_exerciser #(
  parameter int NUM_VEC = 16,
  parameter int SETTLE  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef FIRST_FAIL_LOG_EN
  output logic [7:0] fail_idx,
  output logic       fail_valid,
`endif
  output logic [7:0] err_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       mism;
`ifdef FIRST_FAIL_LOG_EN
  logic [7:0] fidx_q, fidx_d;
  logic       fv_q, fv_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    pass_d  = pass_q;
    mism    = 1'b0;
`ifdef FIRST_FAIL_LOG_EN
    fidx_d  = fidx_q;
    fv_d    = fv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 8'd0;
          err_d   = 8'd0;
          pass_d  = 1'b0;
          a_d     = 1'b0;
`ifdef FIRST_FAIL_LOG_EN
          fidx_d  = 8'd0;
          fv_d    = 1'b0;
`endif
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_INIT;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        mism = (dut_y != ~a_q);
        if (mism && err_q != 8'hff) begin
          err_d = err_q + 8'd1;
        end
`ifdef FIRST_FAIL_LOG_EN
        if (mism && !fv_q) begin
          fv_d   = 1'b1;
          fidx_d = vec_q;
        end
`endif
        if (vec_q == LAST_IDX) begin
          state_d = S_DONE;
          // includes this final sample's result
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 8'd1;
          // stimulus is the LSB of the next vector index
          a_d     = ~vec_q[0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 8'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
`ifdef FIRST_FAIL_LOG_EN
      fidx_q  <= 8'd0;
      fv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef FIRST_FAIL_LOG_EN
      fidx_q  <= fidx_d;
      fv_q    <= fv_d;
`endif
    end
  end

  assign dut_a     = a_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef FIRST_FAIL_LOG_EN
  assign fail_idx   = fidx_q;
  assign fail_valid = fv_q;
`endif

endmodule

// File: tb/tb_not_gate_exerciser.sv
// Directed bench for not_gate_exerciser: three instances
// (defaults, NUM_VEC=255/SETTLE=1, NUM_VEC=1/SETTLE=1).
module tb_not_gate_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // mode: 0 good inverter, 1 stuck-at-0, 2 buffer
  int mode0 = 0;
  int mode1 = 2;

  logic start0 = 1'b0, a0, y0, busy0, done0, pass0;
  logic [7:0] err0;
  logic start1 = 1'b0, a1, y1, busy1, done1, pass1;
  logic [7:0] err1;
  logic start2 = 1'b0, a2, y2, busy2, done2, pass2;
  logic [7:0] err2;
`ifdef FIRST_FAIL_LOG_EN
  logic [7:0] fidx0, fidx1, fidx2;
  logic fv0, fv1, fv2;
`endif

  assign y0 = (mode0 == 0) ? ~a0 : (mode0 == 1) ? 1'b0 : a0;
  assign y1 = (mode1 == 0) ? ~a1 : (mode1 == 1) ? 1'b0 : a1;
  assign y2 = ~a2;

  not_gate_exerciser u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .dut_a(a0), .dut_y(y0), .busy(busy0),
    .done(done0), .pass(pass0),
`ifdef FIRST_FAIL_LOG_EN
    .fail_idx(fidx0), .fail_valid(fv0),
`endif
    .err_count(err0)
  );

  not_gate_exerciser #(.NUM_VEC(255), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_y(y1), .busy(busy1),
    .done(done1), .pass(pass1),
`ifdef FIRST_FAIL_LOG_EN
    .fail_idx(fidx1), .fail_valid(fv1),
`endif
    .err_count(err1)
  );

  not_gate_exerciser #(.NUM_VEC(1), .SETTLE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .dut_a(a2), .dut_y(y2), .busy(busy2),
    .done(done2), .pass(pass2),
`ifdef FIRST_FAIL_LOG_EN
    .fail_idx(fidx2), .fail_valid(fv2),
`endif
    .err_count(err2)
  );

  // Pulse start0 and count edges (accept edge = 1) until done0.
  task automatic run0(output int n);
    start0 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start0 = 1'b0;
    end while (!done0 && n < 200);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({a0, busy0, done0, pass0, err0} !== 12'd0) begin
      fails++;
      $display("FAIL reset_u0 got a=%b busy=%b done=%b pass=%b err=%0d want all 0",
               a0, busy0, done0, pass0, err0);
    end
    tests++;
    if ({busy1, done1, busy2, done2} !== 4'd0) begin
      fails++;
      $display("FAIL reset_others got %b want 0000",
               {busy1, done1, busy2, done2});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    int n;
    mode0 = 0;
    run0(n);
    tests++;
    if (n !== 65) begin
      fails++;
      $display("FAIL good_latency got %0d want 65", n);
    end
    tests++;
    if (pass0 !== 1'b1 || err0 !== 8'd0) begin
      fails++;
      $display("FAIL good_result got pass=%b err=%0d want pass=1 err=0",
               pass0, err0);
    end
    tests++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL good_busy_in_done got %b want 0", busy0);
    end
    @(posedge clk); #1;
    tests++;
    if (done0 !== 1'b0 || a0 !== 1'b1 || pass0 !== 1'b1) begin
      fails++;
      $display("FAIL good_after_done got done=%b a=%b pass=%b want 0 1 1",
               done0, a0, pass0);
    end
  endtask

  task automatic test_stuck0();
    int n;
    mode0 = 1;
    run0(n);
    tests++;
    if (n !== 65 || err0 !== 8'd8 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL stuck0 got n=%0d err=%0d pass=%b want 65 8 0",
               n, err0, pass0);
    end
`ifdef FIRST_FAIL_LOG_EN
    tests++;
    if (fidx0 !== 8'd0 || fv0 !== 1'b1) begin
      fails++;
      $display("FAIL stuck0_log got idx=%0d v=%b want 0 1", fidx0, fv0);
    end
`endif
    @(posedge clk); #1;
    mode0 = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    int pulses;
    mode0 = 0;
    start0 = 1'b1;
    n = 0;
    pulses = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done0 && n < 200);
    tests++;
    if (n !== 65 || pass0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first got n=%0d pass=%b want 65 1", n, pass0);
    end
    @(posedge clk); #1;
    tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done0, busy0);
    end
    @(posedge clk); #1;
    tests++;
    if (busy0 !== 1'b1 || pass0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart got busy=%b pass=%b want 1 0", busy0, pass0);
    end
    n = 1;
    do begin
      @(posedge clk); #1;
      n++;
      if (done0) pulses++;
    end while (!done0 && n < 200);
    start0 = 1'b0;
    tests++;
    if (n !== 65 || pulses !== 1 || pass0 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second got n=%0d pulses=%0d pass=%b want 65 1 1",
               n, pulses, pass0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    mode0 = 2;
    start0 = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    tests++;
    if (busy0 !== 1'b1 || err0 !== 8'd5 || a0 !== 1'b1) begin
      fails++;
      $display("FAIL mid_before got busy=%b err=%0d a=%b want 1 5 1",
               busy0, err0, a0);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a0, busy0, done0, pass0, err0} !== 12'd0) begin
      fails++;
      $display("FAIL mid_async got a=%b busy=%b done=%b pass=%b err=%0d want 0",
               a0, busy0, done0, pass0, err0);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) pulses++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done0 || busy0) pulses++;
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL mid_no_done got %0d want 0", pulses);
    end
    mode0 = 0;
    run0(n);
    tests++;
    if (n !== 65 || pass0 !== 1'b1 || err0 !== 8'd0) begin
      fails++;
      $display("FAIL mid_rerun got n=%0d pass=%b err=%0d want 65 1 0",
               n, pass0, err0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int n;
    mode1 = 2;
    start1 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start1 = 1'b0;
    end while (!done1 && n < 2000);
    tests++;
    if (n !== 766 || err1 !== 8'd255 || pass1 !== 1'b0) begin
      fails++;
      $display("FAIL saturate got n=%0d err=%0d pass=%b want 766 255 0",
               n, err1, pass1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_vec();
    int n;
    int ones;
    start2 = 1'b1;
    n = 0;
    ones = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start2 = 1'b0;
      if (a2) ones++;
    end while (!done2 && n < 50);
    tests++;
    if (n !== 4 || pass2 !== 1'b1 || err2 !== 8'd0) begin
      fails++;
      $display("FAIL single got n=%0d pass=%b err=%0d want 4 1 0",
               n, pass2, err2);
    end
    tests++;
    if (ones !== 0) begin
      fails++;
      $display("FAIL single_dut_a got %0d cycles high want 0", ones);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck0();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_single_vec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
